// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one ALU command at a time and drives an external
// combinational ALU. The command's result is returned on a valid/ready
// response channel.
// Optional feature macro: ALU_SEQUENCER_MUL_EN.
//   When it is defined, op 1000 runs as an N-cycle shift-add multiply through the ALU.
//   When it is undefined, op 1000 is forwarded to the ALU like any other unsupported op.
module alu_sequencer #(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_op,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [N-1:0] alu_result,
  input  logic         alu_zero,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_zero
);

`ifdef ALU_SEQUENCER_MUL_EN
  localparam int unsigned CW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [3:0]  OP_ADD = 4'b0010;
  localparam logic [3:0]  OP_MUL = 4'b1000;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2, MUL = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
`endif

  state_t       state, state_nx;
  logic [3:0]   op_q;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;

`ifdef ALU_SEQUENCER_MUL_EN
  logic [N-1:0]  acc_q;
  logic [CW-1:0] cnt_q;
  logic          mul_last;

  assign mul_last = (cnt_q == CW'(N - 1));
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode, ALU drive and handshake outputs
  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_ctrl  = 4'b0000;
    case (state)
      IDLE: begin
        cmd_ready = !reset;
        if (cmd_valid && !reset) begin
`ifdef ALU_SEQUENCER_MUL_EN
          state_nx = (cmd_op == OP_MUL) ? MUL : EXEC;
`else
          state_nx = EXEC;
`endif
        end
      end
      EXEC: begin
        alu_ctrl = op_q;
        alu_a    = a_q;
        alu_b    = b_q;
        state_nx = RESP;
      end
`ifdef ALU_SEQUENCER_MUL_EN
      MUL: begin
        alu_ctrl = OP_ADD;
        alu_a    = acc_q;
        alu_b    = b_q[cnt_q] ? (a_q << cnt_q) : '0;
        if (mul_last) state_nx = RESP;
      end
`endif
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Command latch, multiply accumulator and response capture
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= 4'b0000;
      a_q        <= '0;
      b_q        <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
`ifdef ALU_SEQUENCER_MUL_EN
      acc_q      <= '0;
      cnt_q      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            a_q   <= cmd_a;
            b_q   <= cmd_b;
`ifdef ALU_SEQUENCER_MUL_EN
            acc_q <= '0;
            cnt_q <= '0;
`endif
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
        end
`ifdef ALU_SEQUENCER_MUL_EN
        MUL: begin
          acc_q <= alu_result;
          cnt_q <= cnt_q + CW'(1);
          if (mul_last) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter: N, 64, datapath width of operands, result and ALU-side buses.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: cmd_valid  input  1  command offered.
REQ-005 SHALL have port: cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at clk edge.
REQ-006 SHALL have port: cmd_op  input  4  operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 PASS-B, 1000 MUL; all other codes are unsupported.
REQ-007 SHALL have ports: cmd_a, cmd_b  input  N  operands.
REQ-008 SHALL have ports: alu_a, alu_b  output  N, alu_ctrl  output  4  drive the external ALU.
REQ-009 SHALL have ports: alu_result  input  N, alu_zero  input  1  returned combinationally by the external ALU in the same cycle.
REQ-010 SHALL have ports: rsp_valid  output  1, rsp_ready  input  1, rsp_result  output  N, rsp_zero  output  1  response channel.

Function
REQ-011 SHALL implement FSM states IDLE, EXEC, MUL, RESP; cmd_ready = (state==IDLE) && !reset.
REQ-012 SHALL latch cmd_op, cmd_a, cmd_b on acceptance; go to MUL if op==1000 (with macro), else EXEC.
REQ-013 In EXEC SHALL drive alu_ctrl=latched op, alu_a/alu_b=latched operands; capture alu_result/alu_zero into rsp_result/rsp_zero at cycle end; go to RESP.
REQ-014 Single-cycle ops SHALL assert rsp_valid exactly 2 edges after the accepting edge.
REQ-015 Unsupported ops SHALL be forwarded to the ALU unchanged; the response is whatever the ALU returns (0, zero=1).
REQ-016 MUL SHALL run exactly N cycles of shift-add via the ALU: alu_ctrl=0010, alu_a=acc, alu_b = multiplier bit i ? (multiplicand<<i) : 0; acc<=alu_result.
REQ-017 MUL result SHALL be low N bits of a*b (unsigned, wraps modulo 2^N); rsp_zero = alu_zero of the final iteration.
REQ-018 In IDLE and RESP SHALL drive alu_a=0, alu_b=0, alu_ctrl=0000.
REQ-019 In RESP SHALL hold rsp_valid=1 and rsp_result/rsp_zero stable until rsp_ready=1 at an edge, then go to IDLE.
REQ-020 SHALL not accept a new command in the cycle a response is consumed (no bypass); cmd_ready rises the cycle after.
REQ-021 rsp_result/rsp_zero SHALL hold the last response value while in IDLE.

Reset
REQ-022 reset high at an edge SHALL force state IDLE, rsp_valid=0, rsp_result=0, rsp_zero=0, acc and iteration counter=0.
REQ-023 reset during EXEC, MUL or RESP SHALL abort the operation with no response emitted.
REQ-024 cmd_ready SHALL read 0 while reset is high.

Configuration
REQ-025 Macro ALU_SEQUENCER_MUL_EN defined: op 1000 SHALL execute as the N-cycle MUL of REQ-016/017.
REQ-026 Macro undefined: MUL state and its registers SHALL be absent; op 1000 SHALL be treated as unsupported (REQ-015) with 2-edge latency.

Verification
REQ-027 ADD a=5, b=7, rsp_ready=1 -> rsp_valid 2 edges after accept, rsp_result=12, rsp_zero=0, alu_ctrl=0010 during EXEC.
REQ-028 SUB a=9, b=9 -> rsp_result=0, rsp_zero=1; SUB a=0, b=1 -> rsp_result=0xFFFF_FFFF_FFFF_FFFF.
REQ-029 Op 0011, a=3, b=4 -> rsp_result=0, rsp_zero=1.
REQ-030 MUL (macro on) a=6, b=7 -> rsp_valid after N+1 edges, rsp_result=42; a=2^63, b=2 -> rsp_result=0, rsp_zero=1.
REQ-031 Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and rsp_result stable, cmd_ready=0, command with cmd_valid=1 not accepted.
REQ-032 Assert reset 10 cycles into a MUL -> next cycle state IDLE, rsp_valid=0, cmd_ready=1 after reset drops, no response emitted.
